// File: rtl/bit_ctrl_monitor.sv
// bit_ctrl_monitor: locks onto the six-step bit-control pattern order and counts sequence errors once locked.
module bit_ctrl_monitor #(
  parameter int LOCK_COUNT = 3,
  parameter int MISS_LIMIT = 2,
  parameter bit ALLOW_HOLD = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] pat_in,
  input  logic       pat_valid,
  input  logic       err_clr,
  output logic [2:0] step,
  output logic       step_valid,
  output logic       locked,
  output logic       err_pulse,
  output logic [7:0] err_count
);
  localparam logic [2:0] LC = 3'(LOCK_COUNT);
  localparam logic [2:0] ML = 3'(MISS_LIMIT);
  typedef enum logic [1:0] {HUNT, ACQUIRE, LOCKED} state_t;
  state_t     state_q, state_d;
  logic [2:0] step_q, step_d, good_q, good_d, miss_q, miss_d;
  logic [7:0] cnt_q, cnt_d;
  logic       pulse_q, pulse_d;
  logic       legal, adv, hold, err;
  logic [2:0] dec, expd;
  always_comb begin
    legal = 1'b1;
    dec   = 3'd0;
    case (pat_in)
      8'h90:   dec = 3'd0;
      8'h18:   dec = 3'd1;
      8'h48:   dec = 3'd2;
      8'h60:   dec = 3'd3;
      8'h24:   dec = 3'd4;
      8'h84:   dec = 3'd5;
      default: legal = 1'b0;
    endcase
    expd = (step_q == 3'd5) ? 3'd0 : step_q + 3'd1;
    adv  = legal && (dec == expd);
    hold = ALLOW_HOLD && legal && (dec == step_q);
    err  = pat_valid && (state_q == LOCKED) && !adv && !hold;
    state_d = state_q;
    step_d  = step_q;
    good_d  = good_q;
    miss_d  = miss_q;
    pulse_d = err;
    // clear takes effect before a same-cycle increment
    cnt_d = err_clr ? 8'd0 : cnt_q;
    if (err && cnt_d != 8'hff) cnt_d = cnt_d + 8'd1;
    if (pat_valid) begin
      case (state_q)
        HUNT: if (legal) begin
          state_d = ACQUIRE;
          step_d  = dec;
          good_d  = 3'd0;
        end
        ACQUIRE: if (!legal) state_d = HUNT;
        else if (adv) begin
          step_d = dec;
          good_d = good_q + 3'd1;
          if (good_q + 3'd1 == LC) begin
            state_d = LOCKED;
            miss_d  = 3'd0;
          end
        end else if (!hold) begin
          step_d = dec;
          good_d = 3'd0;
        end
        LOCKED: if (adv || hold) begin
          step_d = dec;
          miss_d = 3'd0;
        end else begin
          // legal errors resync the step, illegal ones hold it
          step_d = legal ? dec : step_q;
          miss_d = miss_q + 3'd1;
          if (miss_q + 3'd1 == ML) state_d = HUNT;
        end
        default: state_d = HUNT;
      endcase
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= HUNT;
      step_q  <= 3'd0;
      good_q  <= 3'd0;
      miss_q  <= 3'd0;
      cnt_q   <= 8'd0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      good_q  <= good_d;
      miss_q  <= miss_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end
  assign step       = step_q;
  assign step_valid = state_q != HUNT;
  assign locked     = state_q == LOCKED;
  assign err_pulse  = pulse_q;
  assign err_count  = cnt_q;
endmodule

// File: doc/bit_ctrl_monitor.md
Name: bit_ctrl_monitor

Overview:
- Receive-side checker for the 8-bit six-step bit-control pattern bus driven by the sequencer.
- Samples the bus, decodes each pattern to a step index, and acquires lock on the legal step order.
- Once locked, flags out-of-sequence or illegal patterns and counts them for status readback.
- Sits on the far end of the pattern bus, alongside the actuators being driven.

Parameters:
- LOCK_COUNT, 3, consecutive correct step advances required to enter LOCKED (1..7).
- MISS_LIMIT, 2, consecutive errors in LOCKED that force return to HUNT (1..7).
- ALLOW_HOLD, 1, if 1 a repeated step (same pattern as last sample) is legal; if 0 it is an error.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset_n  input  1  asynchronous active-low reset
- pat_in  input  8  sampled pattern bus
- pat_valid  input  1  qualifies pat_in for this cycle; pat_in is ignored when low
- err_clr  input  1  synchronous clear of err_count
- step  output  3  last accepted step index (0..5)
- step_valid  output  1  high when state is ACQUIRE or LOCKED
- locked  output  1  high when state is LOCKED
- err_pulse  output  1  one-cycle pulse per detected error in LOCKED
- err_count  output  8  saturating error counter

Behaviour:
- Decode table, exact match only:
  - 0x90 -> step 0
  - 0x18 -> step 1
  - 0x48 -> step 2
  - 0x60 -> step 3
  - 0x24 -> step 4
  - 0x84 -> step 5
  - Every other value, including 0x00, is illegal.
- expected = (last_step == 5) ? 0 : last_step + 1.
- All outputs are registered and update on the clock edge after the qualifying sample (latency 1).
- Reset (reset_n low, asynchronous): state = HUNT; step = 0, step_valid = 0, locked = 0, err_pulse = 0, err_count = 0; good_cnt = 0, miss_cnt = 0.
- Reset asserted mid-operation discards all state immediately.
- Cycles with pat_valid = 0: no state change; err_pulse = 0.
- HUNT:
  - Legal sample -> ACQUIRE, last_step = decoded, good_cnt = 0.
  - Illegal sample -> stay in HUNT; no error is reported.
- ACQUIRE:
  - decoded == expected -> last_step = decoded, good_cnt++; when good_cnt reaches LOCK_COUNT -> LOCKED with miss_cnt = 0.
  - decoded == last_step and ALLOW_HOLD = 1 -> no change.
  - Any other legal sample -> restart ACQUIRE with last_step = decoded, good_cnt = 0.
  - Illegal sample -> HUNT.
  - No errors are counted in ACQUIRE.
- LOCKED:
  - decoded == expected -> advance last_step, miss_cnt = 0.
  - Hold with ALLOW_HOLD = 1 -> no change, miss_cnt = 0.
  - Anything else is an error:
    - err_pulse = 1 for one cycle.
    - err_count increments, saturating at 255.
    - miss_cnt++.
    - If the sample is legal, last_step resyncs to decoded; if illegal, last_step is held.
  - When miss_cnt reaches MISS_LIMIT -> HUNT on the same edge: locked = 0, step_valid = 0, step holds its last value.
- Wrap-around: step 5 -> step 0 is a correct advance.
- err_clr:
  - Sets err_count = 0.
  - If an error occurs in the same cycle, err_count = 1 (the clear is applied first, then the increment).
  - err_clr does not affect state or err_pulse.
- Saturation: at 255, further errors still pulse err_pulse; the count stays at 255.

Test Plan:
- Reset, then valid samples 0x90,0x18,0x48,0x60 on consecutive cycles (defaults) -> step_valid high after the 0x90 edge; locked rises on the edge after 0x60; step = 3; err_count = 0.
- Locked at step 5, apply 0x90 -> step = 0, no err_pulse (wrap-around); then 0x48 -> err_pulse one cycle, err_count = 1, step = 2, still locked.
- Locked, apply 0xFF, then 0x00 (MISS_LIMIT = 2) -> err_count = 2, locked falls on the second edge, state HUNT; following 0x24 -> step_valid = 1, step = 4, locked = 0.
- Locked at step 2, repeat 0x48 three times: ALLOW_HOLD = 1 -> no errors; ALLOW_HOLD = 0 -> err_pulse on first repeat, unlock after second.
- Force 300 errors with periodic re-lock -> err_count saturates at 255. Assert err_clr with a simultaneous error -> err_count = 1.
- Toggle pat_valid low with garbage on pat_in for 10 cycles -> no change. Drop reset_n mid-lock between edges -> all outputs zero immediately; re-acquire works after release.
